// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for mem_bus_arbiter: FSM states, owner codes and access sizes.
package mem_bus_arbiter_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SIZE_BYTE = 2'b00;
  localparam size_t SIZE_HALF = 2'b01;
  localparam size_t SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      ST_OWN_I: return OWNER_I;
      ST_OWN_D: return OWNER_D;
      default:  return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, data port and unified memory bus of mem_bus_arbiter.
// master is the arbiter's view; slave is the requesters' and memory's view.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready_n;

  logic        d_req;
  logic        d_write;
  size_t       d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready_n;

  logic        m_req;
  logic        m_write;
  size_t       m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  logic        m_busy;

  logic [1:0]  owner;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_write, d_size, d_addr, d_wdata,
    input  m_rdata, m_ready_n, m_busy,
    output i_rdata, i_ready_n,
    output d_rdata, d_ready_n,
    output m_req, m_write, m_size, m_addr, m_wdata,
    output owner
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_write, d_size, d_addr, d_wdata,
    output m_rdata, m_ready_n, m_busy,
    input  i_rdata, i_ready_n,
    input  d_rdata, d_ready_n,
    input  m_req, m_write, m_size, m_addr, m_wdata,
    input  owner
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
// Data wins by default; after STARVE_LIMIT back-to-back D grants with I waiting, I goes first.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  localparam logic [2:0] STREAK_MAX = 3'(STARVE_LIMIT);

  arb_state_t  state;
  arb_state_t  state_next;
  logic [2:0]  streak;
  logic        grant_i;
  logic        grant_d;
  logic        done;
  logic        i_starving;

  logic        m_write_q;
  size_t       m_size_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;

  assign i_starving = bus.i_req && (streak >= STREAK_MAX);
  assign done       = (state != ST_IDLE) && !bus.m_ready_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants happen only from IDLE, which guarantees one idle cycle between transactions.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.m_busy) begin
          if (bus.d_req && !i_starving) begin
            grant_d    = 1'b1;
            state_next = ST_OWN_D;
          end else if (bus.i_req) begin
            grant_i    = 1'b1;
            state_next = ST_OWN_I;
          end
        end
      end
      ST_OWN_I, ST_OWN_D: begin
        if (!bus.m_ready_n) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_write_q <= 1'b0;
      m_size_q  <= SIZE_BYTE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else if (grant_d) begin
      m_write_q <= bus.d_write;
      m_size_q  <= bus.d_size;
      m_addr_q  <= bus.d_addr;
      m_wdata_q <= bus.d_wdata;
    end else if (grant_i) begin
      m_write_q <= 1'b0;
      m_size_q  <= SIZE_WORD;
      m_addr_q  <= bus.i_addr;
      m_wdata_q <= '0;
    end
  end

  // Streak counts D grants that bypassed a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!bus.i_req) begin
        streak <= '0;
      end else if (streak < STREAK_MAX) begin
        streak <= streak + 3'd1;
      end
    end else if (grant_i) begin
      streak <= '0;
    end
  end

  assign bus.m_req   = (state != ST_IDLE);
  assign bus.m_write = m_write_q;
  assign bus.m_size  = m_size_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.owner   = owner_of(state);

  // Completion is forwarded combinationally in the cycle memory signals ready.
  assign bus.i_ready_n = !(done && (state == ST_OWN_I));
  assign bus.d_ready_n = !(done && (state == ST_OWN_D));
  assign bus.i_rdata   = (done && (state == ST_OWN_I)) ? bus.m_rdata : '0;
  assign bus.d_rdata   = (done && (state == ST_OWN_D)) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected grants are queued as stimulus is driven
// and checked against the memory bus when each transaction appears and completes.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
    logic        write;
    size_t       size;
    logic [31:0] wdata;
  } grant_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  grant_t      exp_q[$];
  grant_t      inflight;
  bit          in_valid = 1'b0;
  bit          prev_m_req = 1'b0;
  logic [1:0]  prev_owner = 2'b00;
  int          mem_latency = 2;
  int          lat_cnt = 0;
  logic        resp_ready_n = 1'b1;
  logic [31:0] resp_rdata = '0;
  logic        spur_ready_n = 1'b1;

  mem_bus_arbiter_if bus ();

  assign bus.m_ready_n = resp_ready_n & spur_ready_n;
  assign bus.m_rdata   = spur_ready_n ? resp_rdata : 32'hBAD0_BAD0;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic dwrite, input size_t dsize, input logic [31:0] daddr,
                               input logic [31:0] dwdata);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_write = dwrite;
    bus.d_size  = dsize;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
  endtask

  task automatic idleStimulus();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SIZE_BYTE, 32'h0, 32'h0);
  endtask

  task automatic expectGrant(input logic [1:0] src, input logic [31:0] addr, input logic write,
                             input size_t size, input logic [31:0] wdata);
    grant_t g;
    g.src   = src;
    g.addr  = addr;
    g.write = write;
    g.size  = size;
    g.wdata = wdata;
    exp_q.push_back(g);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit want_d, input int budget, input string tag, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seen = want_d ? (bus.d_ready_n === 1'b0) : (bus.i_ready_n === 1'b0);
    end
    checkOutput(tag, 32'(seen), 1);
  endtask

  // Memory model: completes each transaction mem_latency cycles after m_req rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_ready_n = 1'b1;
      resp_rdata   = '0;
      if (bus.m_req === 1'b1) begin
        lat_cnt++;
        if (lat_cnt == mem_latency) begin
          resp_ready_n = 1'b0;
          resp_rdata   = memModel(bus.m_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Bus monitor: pops the scoreboard on each new grant and checks hold and completion.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        in_valid   = 1'b0;
        prev_m_req = 1'b0;
        prev_owner = OWNER_NONE;
      end else begin
        if (bus.m_req === 1'b1 && !prev_m_req) begin
          checkOutput("grant_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            inflight = exp_q.pop_front();
            in_valid = 1'b1;
            checkOutput("grant_owner", 32'(bus.owner), 32'(inflight.src));
            checkOutput("grant_prev_idle", 32'(prev_owner), 32'(OWNER_NONE));
            checkOutput("grant_addr", bus.m_addr, inflight.addr);
            checkOutput("grant_write", 32'(bus.m_write), 32'(inflight.write));
            checkOutput("grant_size", 32'(bus.m_size), 32'(inflight.size));
            checkOutput("grant_wdata", bus.m_wdata, inflight.wdata);
          end
        end else if (bus.m_req === 1'b1 && in_valid) begin
          checkOutput("hold_owner", 32'(bus.owner), 32'(inflight.src));
          checkOutput("hold_addr", bus.m_addr, inflight.addr);
          checkOutput("hold_size", 32'(bus.m_size), 32'(inflight.size));
          checkOutput("hold_wdata", bus.m_wdata, inflight.wdata);
        end else if (bus.m_req !== 1'b1) begin
          checkOutput("idle_owner", 32'(bus.owner), 32'(OWNER_NONE));
        end
        if (bus.i_ready_n === 1'b0 || bus.d_ready_n === 1'b0) begin
          checkOutput("ready_in_flight", 32'(in_valid), 1);
          checkOutput("ready_src", 32'({bus.i_ready_n, bus.d_ready_n}), 32'(inflight.src));
          if (inflight.src == OWNER_I) begin
            checkOutput("i_rdata", bus.i_rdata, memModel(inflight.addr));
            checkOutput("d_rdata_quiet", bus.d_rdata, 0);
          end else begin
            checkOutput("d_rdata", bus.d_rdata, memModel(inflight.addr));
            checkOutput("i_rdata_quiet", bus.i_rdata, 0);
          end
          in_valid = 1'b0;
        end else begin
          checkOutput("i_rdata_idle", bus.i_rdata, 0);
          checkOutput("d_rdata_idle", bus.d_rdata, 0);
        end
        prev_m_req = bus.m_req;
        prev_owner = bus.owner;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    bus.m_busy = 1'b0;
    idleStimulus();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_m_req", 32'(bus.m_req), 0);
    checkOutput("rst_owner", 32'(bus.owner), 0);
    checkOutput("rst_m_write", 32'(bus.m_write), 0);
    checkOutput("rst_m_size", 32'(bus.m_size), 0);
    checkOutput("rst_m_addr", bus.m_addr, 0);
    checkOutput("rst_m_wdata", bus.m_wdata, 0);
    checkOutput("rst_i_ready_n", 32'(bus.i_ready_n), 1);
    checkOutput("rst_d_ready_n", 32'(bus.d_ready_n), 1);
    checkOutput("rst_i_rdata", bus.i_rdata, 0);
    checkOutput("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b1;

    $display("[TB] fetch only");
    expectGrant(OWNER_I, 32'h100, 1'b0, SIZE_WORD, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, SIZE_BYTE, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("s1_m_req_same_cycle", 32'(bus.m_req), 0);
    @(negedge clk);
    checkOutput("s1_m_req_next_cycle", 32'(bus.m_req), 1);
    waitReady(1'b0, 10, "s1_i_ready", cyc);
    checkOutput("s1_ready_latency", cyc, 1);
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkOutput("s1_pulse_width", 32'(bus.i_ready_n), 1);

    $display("[TB] simultaneous fetch and store");
    expectGrant(OWNER_D, 32'h2000, 1'b1, SIZE_WORD, 32'hDEAD_BEEF);
    expectGrant(OWNER_I, 32'h104, 1'b0, SIZE_WORD, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, SIZE_WORD, 32'h2000, 32'hDEAD_BEEF);
    waitReady(1'b1, 10, "s2_d_ready", cyc);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, SIZE_BYTE, 32'h0, 32'h0);
    waitReady(1'b0, 10, "s2_i_ready", cyc);
    nextCycle();
    idleStimulus();

    $display("[TB] starvation limit");
    for (int k = 0; k < 4; k++) expectGrant(OWNER_D, 32'h3000, 1'b0, SIZE_WORD, 32'h0);
    expectGrant(OWNER_I, 32'h108, 1'b0, SIZE_WORD, 32'h0);
    expectGrant(OWNER_D, 32'h3000, 1'b0, SIZE_WORD, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, SIZE_WORD, 32'h3000, 32'h0);
    for (int k = 0; k < 4; k++) waitReady(1'b1, 10, "s3_d_ready", cyc);
    waitReady(1'b0, 10, "s3_i_ready", cyc);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, SIZE_WORD, 32'h3000, 32'h0);
    waitReady(1'b1, 10, "s3_d_resume", cyc);
    nextCycle();
    idleStimulus();

    $display("[TB] memory busy");
    expectGrant(OWNER_D, 32'h4000, 1'b1, SIZE_HALF, 32'h0000_CAFE);
    nextCycle();
    bus.m_busy = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, SIZE_HALF, 32'h4000, 32'h0000_CAFE);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("s4_busy_hold", 32'(bus.m_req), 0);
    end
    nextCycle();
    bus.m_busy = 1'b0;
    @(negedge clk);
    checkOutput("s4_busy_fall_cycle", 32'(bus.m_req), 0);
    @(negedge clk);
    checkOutput("s4_grant_after_busy", 32'(bus.m_req), 1);
    bus.m_busy = 1'b1;
    waitReady(1'b1, 10, "s4_d_ready_busy_ignored", cyc);
    nextCycle();
    bus.m_busy = 1'b0;
    idleStimulus();

    $display("[TB] reset during data ownership");
    mem_latency = 10;
    expectGrant(OWNER_D, 32'h5000, 1'b0, SIZE_WORD, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, SIZE_WORD, 32'h5000, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("s5_owner_before", 32'(bus.owner), 32'(OWNER_D));
    #2 rst = 1'b0;
    #1;
    checkOutput("s5_m_req_async", 32'(bus.m_req), 0);
    checkOutput("s5_owner_async", 32'(bus.owner), 0);
    checkOutput("s5_m_addr_async", bus.m_addr, 0);
    idleStimulus();
    repeat (2) begin
      @(negedge clk);
      checkOutput("s5_no_d_ready", 32'(bus.d_ready_n), 1);
    end
    rst = 1'b1;
    mem_latency = 2;
    @(negedge clk);
    checkOutput("s5_idle_after", 32'(bus.owner), 32'(OWNER_NONE));

    $display("[TB] spurious memory ready");
    nextCycle();
    spur_ready_n = 1'b0;
    @(negedge clk);
    checkOutput("s6_i_ready_n", 32'(bus.i_ready_n), 1);
    checkOutput("s6_d_ready_n", 32'(bus.d_ready_n), 1);
    checkOutput("s6_i_rdata", bus.i_rdata, 0);
    checkOutput("s6_d_rdata", bus.d_rdata, 0);
    nextCycle();
    spur_ready_n = 1'b1;
    @(negedge clk);
    checkOutput("s6_owner_after", 32'(bus.owner), 32'(OWNER_NONE));
    checkOutput("s6_m_req_after", 32'(bus.m_req), 0);

    $display("[TB] byte load");
    expectGrant(OWNER_D, 32'h44, 1'b0, SIZE_BYTE, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, SIZE_BYTE, 32'h44, 32'h0);
    waitReady(1'b1, 10, "s7_d_ready", cyc);
    nextCycle();
    idleStimulus();
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive D grants allowed while I is waiting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports i_req in 1 (fetch request) and i_addr in 32 (fetch address).
REQ-005 SHALL have ports i_rdata out 32 (fetch data) and i_ready_n out 1 (active-low one-cycle fetch completion).
REQ-006 SHALL have ports d_req in 1, d_write in 1, d_size in 2, d_addr in 32 and d_wdata in 32, forming the data request.
REQ-007 SHALL have ports d_rdata out 32 (load data) and d_ready_n out 1 (active-low one-cycle data completion).
REQ-008 SHALL have ports m_req out 1, m_write out 1, m_size out 2, m_addr out 32 and m_wdata out 32, forming the unified memory request.
REQ-009 SHALL have ports m_rdata in 32, m_ready_n in 1 (active-low completion) and m_busy in 1 (memory cannot accept).
REQ-010 SHALL have port owner, output, 2: 00 none, 01 I, 10 D.

Function
REQ-011 SHALL implement FSM states IDLE, OWN_I and OWN_D.
REQ-012 In IDLE with m_busy=1, the block SHALL stay in IDLE and grant nothing.
REQ-013 In IDLE with m_busy=0, the block SHALL grant D if d_req=1 and NOT (i_req=1 and streak>=STARVE_LIMIT); otherwise it SHALL grant I if i_req=1.
REQ-014 On a grant, the block SHALL register m_addr, m_write, m_size and m_wdata and move to OWN_x, so m_req rises one cycle after the request is sampled.
REQ-015 An I grant SHALL drive m_write=0, m_size=SIZE_WORD (2'b10) and m_wdata=0.
REQ-016 In OWN_x, m_req SHALL be 1 and the m_* fields SHALL be held stable until completion.
REQ-017 In OWN_x with m_ready_n=0, the block SHALL drive x_ready_n=0 and x_rdata=m_rdata combinationally in that same cycle, then go to IDLE.
REQ-018 x_ready_n SHALL be 1 in all other cycles, and x_rdata SHALL be 0 outside its completion cycle.
REQ-019 There SHALL be at least one IDLE cycle between transactions; minimum occupancy is 2 cycles plus memory latency.
REQ-020 The 3-bit streak counter SHALL increment, saturating at STARVE_LIMIT, on a D grant made while i_req=1.
REQ-021 The streak counter SHALL clear on an I grant and on a D grant made while i_req=0.
REQ-022 A requester SHALL hold req and its fields until its ready_n pulse.
REQ-023 If a requester drops req while owned, the transaction SHALL still complete and the ready_n pulse SHALL still be issued.
REQ-024 m_ready_n=0 in IDLE SHALL be ignored.
REQ-025 m_busy SHALL be ignored in the OWN states.
REQ-026 A req arriving in the same cycle as the other requester's completion SHALL be arbitrated in the following IDLE cycle.
REQ-027 owner SHALL reflect the state: IDLE->00, OWN_I->01, OWN_D->10.

Reset
REQ-028 While rst=0, the block SHALL force state IDLE, streak 0, and m_req, m_write, m_size, m_addr, m_wdata and owner all 0.
REQ-029 While rst=0, i_ready_n and d_ready_n SHALL be 1 and i_rdata and d_rdata SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL drop m_req immediately and discard the transaction with no ready_n pulse.

Structure
REQ-031 The FSM state encoding, the owner codes and SIZE_WORD/HALF/BYTE (2'b10/01/00) SHALL live in the shared core package.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Scenario 1: i_req only, i_addr=0x100, memory ready 2 cycles after m_req -> m_addr=0x100, m_write=0, m_size=10, and i_ready_n low for one cycle carrying m_rdata.
REQ-034 Scenario 2: i_req and d_req in the same cycle, d_addr=0x2000, d_write=1, d_wdata=0xDEADBEEF -> D granted first, then I.
REQ-035 Scenario 3: d_req held continuously with i_req held, STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, then D resumes.
REQ-036 Scenario 4: m_busy=1 for 5 cycles with d_req=1 -> m_req stays 0 for those cycles and rises one cycle after m_busy falls.
REQ-037 Scenario 5: rst asserted low while in OWN_D -> m_req=0 asynchronously, no d_ready_n pulse, owner=00.
REQ-038 Scenario 6: spurious m_ready_n=0 in IDLE -> no ready_n pulse, state unchanged.
